// File: rtl/glip_stream_arbiter.sv
// Round-robin N-to-1 stream arbiter; each grant carries up to MAX_BURST words.
// Define GLIP_STREAM_ARBITER_HEADER_EN to emit the granted channel index as a header word before each burst.
module glip_stream_arbiter #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned N         = 4,
    parameter int unsigned MAX_BURST = 8,
    localparam int unsigned CW       = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CW-1:0]      out_channel
);

`ifdef GLIP_STREAM_ARBITER_HEADER_EN
    typedef enum logic [1:0] {IDLE, HEADER, BURST} state_t;
`else
    typedef enum logic [0:0] {IDLE, BURST} state_t;
`endif

    state_t           state_q;
    logic [CW-1:0]    ptr_q;
    logic [CW-1:0]    grant_q;
    logic [7:0]       count_q;

    logic [CW-1:0]    grant_d;
    logic [CW-1:0]    ptr_d;
    logic [CW-1:0]    cand;
    logic             found;
    logic             last_word;
    logic [WIDTH-1:0] in_words [N];

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            in_words[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    // First valid stream at or after ptr, wrapping modulo N (N need not be a power of two).
    always_comb begin
        grant_d = grant_q;
        found   = 1'b0;
        cand    = ptr_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && in_valid[cand]) begin
                found   = 1'b1;
                grant_d = cand;
            end
            cand = (cand == CW'(N - 1)) ? '0 : cand + CW'(1);
        end
    end

    assign ptr_d     = (grant_q == CW'(N - 1)) ? '0 : grant_q + CW'(1);
    assign last_word = (count_q == 8'(MAX_BURST - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|in_valid) begin
                        grant_q <= grant_d;
                        count_q <= '0;
`ifdef GLIP_STREAM_ARBITER_HEADER_EN
                        state_q <= HEADER;
`else
                        state_q <= BURST;
`endif
                    end
                end
`ifdef GLIP_STREAM_ARBITER_HEADER_EN
                HEADER: begin
                    if (out_ready) begin
                        state_q <= BURST;
                    end
                end
`endif
                BURST: begin
                    if (!in_valid[grant_q]) begin
                        state_q <= IDLE;
                        ptr_q   <= ptr_d;
                    end else if (out_ready) begin
                        count_q <= count_q + 8'd1;
                        if (last_word) begin
                            state_q <= IDLE;
                            ptr_q   <= ptr_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while rst is high so no handshake completes in the reset cycle.
    always_comb begin
        out_valid   = 1'b0;
        out_data    = '0;
        out_channel = '0;
        in_ready    = '0;
        if (!rst) begin
            case (state_q)
                BURST: begin
                    out_valid         = in_valid[grant_q];
                    out_data          = in_words[grant_q];
                    out_channel       = grant_q;
                    in_ready[grant_q] = out_ready;
                end
`ifdef GLIP_STREAM_ARBITER_HEADER_EN
                HEADER: begin
                    out_valid          = 1'b1;
                    out_data[CW-1:0]   = grant_q;
                    out_channel        = grant_q;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_glip_stream_arbiter.sv
// Self-checking bench for glip_stream_arbiter: directed scenarios plus a randomized run against a queue-based model.
// Header tests run only when GLIP_STREAM_ARBITER_HEADER_EN is defined.
module tb_glip_stream_arbiter;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MB = 8;
    localparam int CW = 2;
`ifdef GLIP_STREAM_ARBITER_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [CW-1:0]  out_channel;

    always #5 clk = ~clk;

    glip_stream_arbiter #(.WIDTH(W), .N(N), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int stall_until = 0;

    // Per-stream source FIFOs (circular, 64 entries).
    logic [W-1:0] src_mem [N][64];
    int           src_rd [N];
    int           src_wr [N];
    bit           en [N];

    int           log_ch [$];
    logic [W-1:0] log_data [$];
    logic         vld_hist [$];
    logic         rdy_hist [$];
    logic [W-1:0] data_hist [$];
    int           exp_ch [$];
    logic [W-1:0] exp_dat [$];

    task automatic push_word(input int i, input logic [W-1:0] w);
        src_mem[i][src_wr[i] % 64] = w;
        src_wr[i]++;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
            en[i] = 1'b0;
        end
        log_ch.delete(); log_data.delete(); vld_hist.delete(); rdy_hist.delete(); data_hist.delete();
        exp_ch.delete(); exp_dat.delete();
    endtask

    task automatic clear_logs();
        log_ch.delete(); log_data.delete(); vld_hist.delete(); rdy_hist.delete(); data_hist.delete();
        exp_ch.delete(); exp_dat.delete();
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            in_valid[i] = en[i] && (src_wr[i] != src_rd[i]);
            in_data[i*W +: W] = in_valid[i] ? src_mem[i][src_rd[i] % 64] : W'($urandom);
        end
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = (cyc % 2 == 0);
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = (cyc >= stall_until);
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = '0;
        clear_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Sources pop on the DUT's handshake; everything observed is logged for the tests to judge.
    task automatic run_cycles(input int n);
        logic [N-1:0] pm;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drive_inputs();
            #1;
            vld_hist.push_back(out_valid);
            rdy_hist.push_back(out_ready);
            data_hist.push_back(out_data);
            if (out_valid && out_ready) begin
                log_ch.push_back(int'(out_channel));
                log_data.push_back(out_data);
            end
            pm = in_valid & in_ready;
            @(posedge clk);
            for (int i = 0; i < N; i++) if (pm[i]) src_rd[i]++;
            cyc++;
        end
    endtask

    task automatic test_reset();
        clear_all();
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b1;
            push_word(i, W'(16'h0A00 + i));
        end
        rdy_mode = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rst = (k < 3);
            drive_inputs();
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid k=%0d got %b want 0", k, out_valid); end
            n_checks++;
            if (in_ready !== '0) begin n_fail++; $display("FAIL reset_in_ready k=%0d got %b want 0", k, in_ready); end
            n_checks++;
            if (out_channel !== '0) begin n_fail++; $display("FAIL reset_channel k=%0d got %0d want 0", k, out_channel); end
            n_checks++;
            if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data k=%0d got %h want 0", k, out_data); end
            @(posedge clk);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b1;
            for (int k = 0; k < 16; k++) push_word(i, W'(i * 256 + k));
        end
        rdy_mode = 0;
        run_cycles(45);
        for (int k = 0; k < 45; k++) begin
            n_checks++;
            if (vld_hist[k] !== (k % 9 != 0)) begin
                n_fail++; $display("FAIL rr_valid_timing k=%0d got %b want %b", k, vld_hist[k], (k % 9 != 0));
            end
        end
        for (int j = 0; j < 40; j++) begin
            exp_ch.push_back((j / 8) % 4);
            exp_dat.push_back(W'(((j / 8) % 4) * 256 + ((j / 8) / 4) * 8 + (j % 8)));
        end
        n_checks++;
        if (log_ch.size() != exp_ch.size()) begin
            n_fail++; $display("FAIL rr_count got %0d want %0d", log_ch.size(), exp_ch.size());
        end
        for (int j = 0; j < exp_ch.size() && j < log_ch.size(); j++) begin
            n_checks++;
            if (log_ch[j] != exp_ch[j] || log_data[j] !== exp_dat[j]) begin
                n_fail++; $display("FAIL rr_word j=%0d got ch%0d/%h want ch%0d/%h", j, log_ch[j], log_data[j], exp_ch[j], exp_dat[j]);
            end
        end
    endtask

    task automatic test_single_and_wrap();
        do_reset();
        rdy_mode = 0;
        en[2] = 1'b1;
        for (int k = 0; k < 3; k++) push_word(2, W'(16'h0200 + k));
        run_cycles(6);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (vld_hist[k] !== (k >= 1 && k <= 3)) begin
                n_fail++; $display("FAIL single_valid k=%0d got %b want %b", k, vld_hist[k], (k >= 1 && k <= 3));
            end
        end
        for (int k = 0; k < 3; k++) begin exp_ch.push_back(2); exp_dat.push_back(W'(16'h0200 + k)); end
        n_checks++;
        if (log_ch.size() != 3) begin n_fail++; $display("FAIL single_count got %0d want 3", log_ch.size()); end
        for (int j = 0; j < 3 && j < log_ch.size(); j++) begin
            n_checks++;
            if (log_ch[j] != exp_ch[j] || log_data[j] !== exp_dat[j]) begin
                n_fail++; $display("FAIL single_word j=%0d got ch%0d/%h want ch%0d/%h", j, log_ch[j], log_data[j], exp_ch[j], exp_dat[j]);
            end
        end
        // ptr now 3: streams 0 and 3 both pending, 3 must win and 0 follows.
        clear_logs();
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        push_word(0, 16'h0000); push_word(0, 16'h0001);
        push_word(3, 16'h0300); push_word(3, 16'h0301);
        run_cycles(10);
        exp_ch = '{3, 3, 0, 0};
        exp_dat = '{16'h0300, 16'h0301, 16'h0000, 16'h0001};
        n_checks++;
        if (log_ch.size() != 4) begin n_fail++; $display("FAIL wrap_count got %0d want 4", log_ch.size()); end
        for (int j = 0; j < 4 && j < log_ch.size(); j++) begin
            n_checks++;
            if (log_ch[j] != exp_ch[j] || log_data[j] !== exp_dat[j]) begin
                n_fail++; $display("FAIL wrap_word j=%0d got ch%0d/%h want ch%0d/%h", j, log_ch[j], log_data[j], exp_ch[j], exp_dat[j]);
            end
        end
        // Lone stream 1 with more than one burst of data is re-granted after one idle cycle.
        clear_logs();
        for (int k = 0; k < 10; k++) push_word(1, W'(16'h0100 + k));
        run_cycles(14);
        n_checks++;
        if (vld_hist[9] !== 1'b0 || vld_hist[10] !== 1'b1) begin
            n_fail++; $display("FAIL regrant_gap got %b%b want 01", vld_hist[9], vld_hist[10]);
        end
        n_checks++;
        if (log_ch.size() != 10) begin n_fail++; $display("FAIL regrant_count got %0d want 10", log_ch.size()); end
        for (int j = 0; j < 10 && j < log_ch.size(); j++) begin
            n_checks++;
            if (log_ch[j] != 1 || log_data[j] !== W'(16'h0100 + j)) begin
                n_fail++; $display("FAIL regrant_word j=%0d got ch%0d/%h want ch1/%h", j, log_ch[j], log_data[j], W'(16'h0100 + j));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        rdy_mode = 1;
        en[0] = 1'b1; en[1] = 1'b1;
        for (int k = 0; k < 10; k++) push_word(0, W'(16'h0000 + k));
        for (int k = 0; k < 3; k++) push_word(1, W'(16'h0100 + k));
        run_cycles(36);
        for (int k = 0; k < 8; k++) begin exp_ch.push_back(0); exp_dat.push_back(W'(k)); end
        for (int k = 0; k < 3; k++) begin exp_ch.push_back(1); exp_dat.push_back(W'(16'h0100 + k)); end
        for (int k = 8; k < 10; k++) begin exp_ch.push_back(0); exp_dat.push_back(W'(k)); end
        n_checks++;
        if (log_ch.size() != exp_ch.size()) begin n_fail++; $display("FAIL stall_count got %0d want %0d", log_ch.size(), exp_ch.size()); end
        for (int j = 0; j < exp_ch.size() && j < log_ch.size(); j++) begin
            n_checks++;
            if (log_ch[j] != exp_ch[j] || log_data[j] !== exp_dat[j]) begin
                n_fail++; $display("FAIL stall_word j=%0d got ch%0d/%h want ch%0d/%h", j, log_ch[j], log_data[j], exp_ch[j], exp_dat[j]);
            end
        end
        for (int k = 0; k + 1 < vld_hist.size(); k++) begin
            if (vld_hist[k] && !rdy_hist[k]) begin
                n_checks++;
                if (vld_hist[k+1] !== 1'b1 || data_hist[k+1] !== data_hist[k]) begin
                    n_fail++; $display("FAIL stall_hold k=%0d got v%b/%h want v1/%h", k, vld_hist[k+1], data_hist[k+1], data_hist[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        rdy_mode = 0;
        en[1] = 1'b1;
        for (int k = 0; k < 8; k++) push_word(1, W'(16'h0100 + k));
        run_cycles(5);
        n_checks++;
        if (log_ch.size() != 4) begin n_fail++; $display("FAIL midrst_pre_count got %0d want 4", log_ch.size()); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        push_word(0, 16'h0000); push_word(0, 16'h0001);
        drive_inputs();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== '0) begin
            n_fail++; $display("FAIL midrst_during got v%b r%b want v0 r0", out_valid, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive_inputs();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== '0 || out_channel !== '0 || out_data !== '0) begin
            n_fail++; $display("FAIL midrst_after got v%b r%b c%0d d%h want all 0", out_valid, in_ready, out_channel, out_data);
        end
        n_checks++;
        if (src_wr[1] - src_rd[1] != 4) begin
            n_fail++; $display("FAIL midrst_pending got %0d want 4", src_wr[1] - src_rd[1]);
        end
        @(posedge clk);
        clear_logs();
        run_cycles(12);
        exp_ch = '{0, 0, 1, 1, 1, 1};
        exp_dat = '{16'h0000, 16'h0001, 16'h0104, 16'h0105, 16'h0106, 16'h0107};
        n_checks++;
        if (log_ch.size() != 6) begin n_fail++; $display("FAIL midrst_count got %0d want 6", log_ch.size()); end
        for (int j = 0; j < 6 && j < log_ch.size(); j++) begin
            n_checks++;
            if (log_ch[j] != exp_ch[j] || log_data[j] !== exp_dat[j]) begin
                n_fail++; $display("FAIL midrst_word j=%0d got ch%0d/%h want ch%0d/%h", j, log_ch[j], log_data[j], exp_ch[j], exp_dat[j]);
            end
        end
    endtask

`ifdef GLIP_STREAM_ARBITER_HEADER_EN
    task automatic test_header();
        do_reset();
        rdy_mode = 3;
        stall_until = 4;
        en[1] = 1'b1;
        push_word(1, 16'h01AA); push_word(1, 16'h01BB);
        run_cycles(8);
        for (int k = 1; k < 4; k++) begin
            n_checks++;
            if (vld_hist[k] !== 1'b1 || data_hist[k] !== W'(1)) begin
                n_fail++; $display("FAIL hdr_hold k=%0d got v%b/%h want v1/0001", k, vld_hist[k], data_hist[k]);
            end
        end
        exp_ch = '{1, 1, 1};
        exp_dat = '{16'h0001, 16'h01AA, 16'h01BB};
        n_checks++;
        if (log_ch.size() != 3) begin n_fail++; $display("FAIL hdr_count got %0d want 3", log_ch.size()); end
        for (int j = 0; j < 3 && j < log_ch.size(); j++) begin
            n_checks++;
            if (log_ch[j] != exp_ch[j] || log_data[j] !== exp_dat[j]) begin
                n_fail++; $display("FAIL hdr_word j=%0d got ch%0d/%h want ch%0d/%h", j, log_ch[j], log_data[j], exp_ch[j], exp_dat[j]);
            end
        end
    endtask
`endif

    // Transaction model: owner = stream holding the grant (-1 none), sent = words in this grant.
    task automatic test_random();
        int owner, sent, ptr, c;
        bit hdr, hit;
        logic           e_v;
        logic [W-1:0]   e_d;
        logic [CW-1:0]  e_c;
        logic [N-1:0]   e_r;
        do_reset();
        rdy_mode = 2;
        owner = -1; sent = 0; ptr = 0; hdr = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0 && (src_wr[i] - src_rd[i]) < 6) push_word(i, W'($urandom));
                en[i] = ($urandom_range(0, 4) != 0);
            end
            rst = ($urandom_range(0, 99) == 0);
            drive_inputs();
            e_v = 1'b0; e_d = '0; e_c = '0; e_r = '0;
            if (!rst && owner >= 0) begin
                e_c = CW'(owner);
                if (hdr) begin
                    e_v = 1'b1;
                    e_d = W'(owner);
                end else begin
                    e_v = in_valid[owner];
                    e_d = in_data[owner*W +: W];
                    e_r[owner] = out_ready;
                end
            end
            #1;
            n_checks++;
            if (out_valid !== e_v || out_data !== e_d || out_channel !== e_c || in_ready !== e_r) begin
                n_fail++;
                $display("FAIL random t=%0d got v%b d%h c%0d r%b want v%b d%h c%0d r%b",
                         t, out_valid, out_data, out_channel, in_ready, e_v, e_d, e_c, e_r);
            end
            @(posedge clk);
            if (rst) begin
                owner = -1; ptr = 0; hdr = 1'b0;
            end else if (owner < 0) begin
                hit = 1'b0;
                for (int j = 0; j < N; j++) begin
                    c = (ptr + j) % N;
                    if (!hit && in_valid[c]) begin
                        hit = 1'b1; owner = c; sent = 0; hdr = HDR;
                    end
                end
            end else if (hdr) begin
                if (out_ready) hdr = 1'b0;
            end else if (!in_valid[owner]) begin
                ptr = (owner + 1) % N; owner = -1;
            end else if (out_ready) begin
                src_rd[owner]++;
                sent++;
                if (sent == MB) begin ptr = (owner + 1) % N; owner = -1; end
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef GLIP_STREAM_ARBITER_HEADER_EN
        test_header();
`else
        test_round_robin();
        test_single_and_wrap();
        test_stall();
        test_reset_mid_burst();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "simulation time limit");
    end

endmodule
